// File: rtl/clkdiv_pkg.sv
// Shared types and constants for the multi-channel clock/tick divider.
package clkdiv_pkg;

    typedef enum logic {
        CLKDIV_TOGGLE = 1'b0,
        CLKDIV_PULSE  = 1'b1
    } clkdiv_mode_e;

    // 1 Hz square wave from the 50 MHz board clock
    localparam logic [31:0] CLKDIV_DEFAULT_DIV = 32'd25_000_000;

    function automatic int clkdiv_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Channel-select width, never narrower than one bit
    function automatic int clkdiv_ch_w(input int n_ch);
        int w;
        w = clkdiv_clog2(n_ch);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Configuration bus of the divider: write strobe, channel select, divisor, mode and busy flags.
interface clkdiv_if
    import clkdiv_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int W    = 32
) ();

    localparam int CH_W = clkdiv_ch_w(N_CH);

    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [W-1:0]        cfg_div;
    logic                cfg_mode;
    logic [N_CH-1:0]     cfg_busy;

    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_div,
        output cfg_mode,
        input  cfg_busy
    );

    modport slave (
        input  cfg_we,
        input  cfg_ch,
        input  cfg_div,
        input  cfg_mode,
        output cfg_busy
    );

endinterface

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active and pending configuration, registered outputs.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int             W           = 32,
    parameter logic [W-1:0]   DEFAULT_DIV = W'(CLKDIV_DEFAULT_DIV)
) (
    input  logic          cin,
    input  logic          reset,
    input  logic          en,
    input  logic          cfg_we,
    input  logic [W-1:0]  cfg_div,
    input  logic          cfg_mode,
    output logic          cfg_busy,
    output logic          tick,
    output logic          cout
);

    logic [W-1:0]  count_reg, count_next;
    logic [W-1:0]  div_act_reg, div_act_next;
    logic [W-1:0]  div_pend_reg, div_pend_next;
    clkdiv_mode_e  mode_act_reg, mode_act_next;
    clkdiv_mode_e  mode_pend_reg, mode_pend_next;
    logic          pend_reg, pend_next;
    logic          cout_q_reg, cout_q_next;
    logic          tick_q_reg, tick_q_next;
    logic          cout_reg, cout_next;

    logic [W-1:0]  deff;
    logic          terminal;
    logic          apply;

    // A zero divisor behaves as one; >= lets a shrunken divisor wrap at once
    assign deff     = (div_act_reg == '0) ? W'(1) : div_act_reg;
    assign terminal = en && (count_reg >= (deff - W'(1)));
    assign apply    = pend_reg && (terminal || !en);

    always_comb begin
        count_next     = count_reg;
        div_act_next   = div_act_reg;
        div_pend_next  = div_pend_reg;
        mode_act_next  = mode_act_reg;
        mode_pend_next = mode_pend_reg;
        pend_next      = pend_reg;
        cout_q_next    = cout_q_reg;
        tick_q_next    = 1'b0;

        if (en) begin
            if (terminal) begin
                count_next  = '0;
                tick_q_next = 1'b1;
                cout_q_next = ~cout_q_reg;
            end else begin
                count_next = count_reg + W'(1);
            end
        end

        if (apply) begin
            div_act_next  = div_pend_reg;
            mode_act_next = mode_pend_reg;
            pend_next     = 1'b0;
            if (!en) begin
                count_next = '0;
            end
        end

        // A write in the apply cycle stays pending; the apply used the old values
        if (cfg_we) begin
            div_pend_next  = cfg_div;
            mode_pend_next = clkdiv_mode_e'(cfg_mode);
            pend_next      = 1'b1;
        end

        cout_next = (mode_act_next == CLKDIV_PULSE) ? tick_q_next : cout_q_next;
    end

    always_ff @(posedge cin) begin
        if (reset) begin
            count_reg     <= '0;
            div_act_reg   <= DEFAULT_DIV;
            div_pend_reg  <= DEFAULT_DIV;
            mode_act_reg  <= CLKDIV_TOGGLE;
            mode_pend_reg <= CLKDIV_TOGGLE;
            pend_reg      <= 1'b0;
            cout_q_reg    <= 1'b0;
            tick_q_reg    <= 1'b0;
            cout_reg      <= 1'b0;
        end else begin
            count_reg     <= count_next;
            div_act_reg   <= div_act_next;
            div_pend_reg  <= div_pend_next;
            mode_act_reg  <= mode_act_next;
            mode_pend_reg <= mode_pend_next;
            pend_reg      <= pend_next;
            cout_q_reg    <= cout_q_next;
            tick_q_reg    <= tick_q_next;
            cout_reg      <= cout_next;
        end
    end

    assign cfg_busy = pend_reg;
    assign tick     = tick_q_reg;
    assign cout     = cout_reg;

endmodule

// File: rtl/clkdiv_multi.sv
// N_CH independent run-time programmable dividers sharing one configuration bus.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int            N_CH        = 4,
    parameter int            W           = 32,
    parameter logic [W-1:0]  DEFAULT_DIV = W'(CLKDIV_DEFAULT_DIV)
) (
    input  logic             cin,
    input  logic             reset,
    input  logic [N_CH-1:0]  en,
    clkdiv_if.slave          cfg,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  cout
);

    localparam int CH_W = clkdiv_ch_w(N_CH);

    logic [N_CH-1:0] ch_we;
    logic [N_CH-1:0] ch_busy;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            // Addresses at or beyond N_CH match no channel and are dropped
            assign ch_we[gi] = cfg.cfg_we && (cfg.cfg_ch == CH_W'(gi));

            clkdiv_channel #(
                .W           (W),
                .DEFAULT_DIV (DEFAULT_DIV)
            ) u_channel (
                .cin      (cin),
                .reset    (reset),
                .en       (en[gi]),
                .cfg_we   (ch_we[gi]),
                .cfg_div  (cfg.cfg_div),
                .cfg_mode (cfg.cfg_mode),
                .cfg_busy (ch_busy[gi]),
                .tick     (tick[gi]),
                .cout     (cout[gi])
            );
        end
    endgenerate

    assign cfg.cfg_busy = ch_busy;

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scenario bench for clkdiv_multi with DEFAULT_DIV = 5; expectations queued per edge.
module tb_clkdiv_multi;

    logic       cin = 1'b0;
    logic       reset;
    logic [3:0] en;
    logic [3:0] tick, cout;
    logic [2:0] tick3, cout3;

    int vectors    = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        int         k;
        logic [3:0] tick;
        logic [3:0] cout;
        logic [3:0] busy;
    } exp_t;

    exp_t sb[$];

    clkdiv_if #(.N_CH(4), .W(32)) cfg();
    clkdiv_if #(.N_CH(3), .W(32)) cfg3();

    clkdiv_multi #(.N_CH(4), .W(32), .DEFAULT_DIV(32'd5)) dut (
        .cin(cin), .reset(reset), .en(en), .cfg(cfg), .tick(tick), .cout(cout)
    );

    clkdiv_multi #(.N_CH(3), .W(32), .DEFAULT_DIV(32'd5)) dut3 (
        .cin(cin), .reset(reset), .en(3'b111), .cfg(cfg3), .tick(tick3), .cout(cout3)
    );

    always #5 cin = ~cin;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=still running exp=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge cin);
        #1;
    endtask

    // Default period of 5 enabled edges after reset
    function automatic logic d_tick(input int k);
        return (k > 0) && (k % 5 == 0);
    endfunction

    function automatic logic d_cout(input int k);
        return ((k / 5) % 2) == 1;
    endfunction

    task automatic drive_cfg(input logic we, input logic [1:0] ch, input logic [31:0] div, input logic mode);
        cfg.cfg_we   = we;
        cfg.cfg_ch   = ch;
        cfg.cfg_div  = div;
        cfg.cfg_mode = mode;
    endtask

    task automatic do_reset(input logic [3:0] en_val);
        drive_cfg(1'b0, 2'd0, 32'd0, 1'b0);
        cfg3.cfg_we = 1'b0;
        reset = 1'b1;
        en    = en_val;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        en    = 4'b1111;
        drive_cfg(1'b1, 2'd0, 32'd1, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            e = '{tag: "reset", k: k, tick: 4'b0, cout: 4'b0, busy: 4'b0};
            sb.push_back(e);
            step();
            e = sb.pop_front();
            vectors += 3;
            if (tick !== e.tick) begin miscompares++; $display("FAIL %s k=%0d tick got=%b exp=%b", e.tag, e.k, tick, e.tick); end
            if (cout !== e.cout) begin miscompares++; $display("FAIL %s k=%0d cout got=%b exp=%b", e.tag, e.k, cout, e.cout); end
            if (cfg.cfg_busy !== e.busy) begin miscompares++; $display("FAIL %s k=%0d busy got=%b exp=%b", e.tag, e.k, cfg.cfg_busy, e.busy); end
        end
        $display("test_reset done");
    endtask

    task automatic test_default();
        exp_t e;
        do_reset(4'b1111);
        for (int k = 1; k <= 16; k++) begin
            e = '{tag: "default", k: k, tick: {4{d_tick(k)}}, cout: {4{d_cout(k)}}, busy: 4'b0};
            sb.push_back(e);
            step();
            e = sb.pop_front();
            vectors += 3;
            if (tick !== e.tick) begin miscompares++; $display("FAIL %s k=%0d tick got=%b exp=%b", e.tag, e.k, tick, e.tick); end
            if (cout !== e.cout) begin miscompares++; $display("FAIL %s k=%0d cout got=%b exp=%b", e.tag, e.k, cout, e.cout); end
            if (cfg.cfg_busy !== e.busy) begin miscompares++; $display("FAIL %s k=%0d busy got=%b exp=%b", e.tag, e.k, cfg.cfg_busy, e.busy); end
        end
        $display("test_default done");
    endtask

    // ch1 switched to D=3 PULSE mid-period; takes effect at the old terminal (edge 5)
    task automatic test_pulse_reprogram();
        exp_t e;
        logic t1;
        do_reset(4'b1111);
        for (int k = 1; k <= 18; k++) begin
            drive_cfg(k == 3, 2'd1, 32'd3, 1'b1);
            t1 = (k == 5) || (k > 5 && (k - 5) % 3 == 0);
            e = '{tag: "pulse_ch1", k: k,
                  tick: {d_tick(k), d_tick(k), t1, d_tick(k)},
                  cout: {d_cout(k), d_cout(k), t1, d_cout(k)},
                  busy: {2'b00, (k == 3 || k == 4), 1'b0}};
            sb.push_back(e);
            step();
            e = sb.pop_front();
            vectors += 3;
            if (tick !== e.tick) begin miscompares++; $display("FAIL %s k=%0d tick got=%b exp=%b", e.tag, e.k, tick, e.tick); end
            if (cout !== e.cout) begin miscompares++; $display("FAIL %s k=%0d cout got=%b exp=%b", e.tag, e.k, cout, e.cout); end
            if (cfg.cfg_busy !== e.busy) begin miscompares++; $display("FAIL %s k=%0d busy got=%b exp=%b", e.tag, e.k, cfg.cfg_busy, e.busy); end
        end
        drive_cfg(1'b0, 2'd0, 32'd0, 1'b0);
        $display("test_pulse_reprogram done");
    endtask

    // ch2 gets D=0 (applies at edge 5) then D=1 at edge 10: tick every cycle either way
    task automatic test_div_zero_one();
        exp_t e;
        logic t2, c2, b2;
        do_reset(4'b1111);
        for (int k = 1; k <= 16; k++) begin
            if (k == 1)       drive_cfg(1'b1, 2'd2, 32'd0, 1'b0);
            else if (k == 10) drive_cfg(1'b1, 2'd2, 32'd1, 1'b0);
            else              drive_cfg(1'b0, 2'd2, 32'd0, 1'b0);
            t2 = (k >= 5);
            c2 = (k >= 5) && (k % 2 == 1);
            b2 = (k <= 4) || (k == 10);
            e = '{tag: "div01_ch2", k: k,
                  tick: {d_tick(k), t2, d_tick(k), d_tick(k)},
                  cout: {d_cout(k), c2, d_cout(k), d_cout(k)},
                  busy: {1'b0, b2, 2'b00}};
            sb.push_back(e);
            step();
            e = sb.pop_front();
            vectors += 3;
            if (tick !== e.tick) begin miscompares++; $display("FAIL %s k=%0d tick got=%b exp=%b", e.tag, e.k, tick, e.tick); end
            if (cout !== e.cout) begin miscompares++; $display("FAIL %s k=%0d cout got=%b exp=%b", e.tag, e.k, cout, e.cout); end
            if (cfg.cfg_busy !== e.busy) begin miscompares++; $display("FAIL %s k=%0d busy got=%b exp=%b", e.tag, e.k, cfg.cfg_busy, e.busy); end
        end
        drive_cfg(1'b0, 2'd0, 32'd0, 1'b0);
        $display("test_div_zero_one done");
    endtask

    // ch3 frozen on edges 8..16 with cout held high; D=4 written at 15, applied at 16
    task automatic test_freeze();
        exp_t e;
        logic t3, c3;
        do_reset(4'b1111);
        for (int k = 1; k <= 25; k++) begin
            en = {!(k >= 8 && k <= 16), 3'b111};
            drive_cfg(k == 15, 2'd3, 32'd4, 1'b0);
            t3 = (k == 5) || (k == 20) || (k == 24);
            c3 = (k >= 5 && k < 20) || (k >= 24);
            e = '{tag: "freeze_ch3", k: k,
                  tick: {t3, d_tick(k), d_tick(k), d_tick(k)},
                  cout: {c3, d_cout(k), d_cout(k), d_cout(k)},
                  busy: {(k == 15), 3'b000}};
            sb.push_back(e);
            step();
            e = sb.pop_front();
            vectors += 3;
            if (tick !== e.tick) begin miscompares++; $display("FAIL %s k=%0d tick got=%b exp=%b", e.tag, e.k, tick, e.tick); end
            if (cout !== e.cout) begin miscompares++; $display("FAIL %s k=%0d cout got=%b exp=%b", e.tag, e.k, cout, e.cout); end
            if (cfg.cfg_busy !== e.busy) begin miscompares++; $display("FAIL %s k=%0d busy got=%b exp=%b", e.tag, e.k, cfg.cfg_busy, e.busy); end
        end
        drive_cfg(1'b0, 2'd0, 32'd0, 1'b0);
        en = 4'b1111;
        $display("test_freeze done");
    endtask

    // ch0 written D=8 then D=2 before terminal; 3-channel copy gets an out-of-range address
    task automatic test_last_write_wins();
        exp_t e;
        logic t0, c0;
        logic [2:0] x_tick;
        do_reset(4'b1111);
        for (int k = 1; k <= 14; k++) begin
            if (k == 1)      drive_cfg(1'b1, 2'd0, 32'd8, 1'b0);
            else if (k == 2) drive_cfg(1'b1, 2'd0, 32'd2, 1'b0);
            else             drive_cfg(1'b0, 2'd0, 32'd0, 1'b0);
            cfg3.cfg_we   = (k <= 2);
            cfg3.cfg_ch   = 2'd3;
            cfg3.cfg_div  = 32'd1;
            cfg3.cfg_mode = 1'b1;
            t0 = (k == 5) || (k > 5 && (k - 5) % 2 == 0);
            c0 = (k >= 5) && (((k - 5) / 2) % 2 == 0);
            e = '{tag: "lww_ch0", k: k,
                  tick: {d_tick(k), d_tick(k), d_tick(k), t0},
                  cout: {d_cout(k), d_cout(k), d_cout(k), c0},
                  busy: {3'b000, (k <= 4)}};
            sb.push_back(e);
            e.tag  = "oor_3ch";
            e.tick = {1'b0, {3{d_tick(k)}}};
            e.cout = {1'b0, {3{d_cout(k)}}};
            e.busy = 4'b0;
            sb.push_back(e);
            step();
            e = sb.pop_front();
            vectors += 3;
            if (tick !== e.tick) begin miscompares++; $display("FAIL %s k=%0d tick got=%b exp=%b", e.tag, e.k, tick, e.tick); end
            if (cout !== e.cout) begin miscompares++; $display("FAIL %s k=%0d cout got=%b exp=%b", e.tag, e.k, cout, e.cout); end
            if (cfg.cfg_busy !== e.busy) begin miscompares++; $display("FAIL %s k=%0d busy got=%b exp=%b", e.tag, e.k, cfg.cfg_busy, e.busy); end
            e = sb.pop_front();
            x_tick = e.tick[2:0];
            vectors += 3;
            if (tick3 !== x_tick) begin miscompares++; $display("FAIL %s k=%0d tick got=%b exp=%b", e.tag, e.k, tick3, x_tick); end
            if (cout3 !== e.cout[2:0]) begin miscompares++; $display("FAIL %s k=%0d cout got=%b exp=%b", e.tag, e.k, cout3, e.cout[2:0]); end
            if (cfg3.cfg_busy !== e.busy[2:0]) begin miscompares++; $display("FAIL %s k=%0d busy got=%b exp=%b", e.tag, e.k, cfg3.cfg_busy, e.busy[2:0]); end
        end
        drive_cfg(1'b0, 2'd0, 32'd0, 1'b0);
        cfg3.cfg_we = 1'b0;
        $display("test_last_write_wins done");
    endtask

    // Reset with ch1 pending and a simultaneous write: all cleared, default period resumes
    task automatic test_reset_mid();
        exp_t e;
        do_reset(4'b1111);
        for (int k = 1; k <= 14; k++) begin
            reset = (k == 4);
            if (k == 2)      drive_cfg(1'b1, 2'd1, 32'd2, 1'b1);
            else if (k == 4) drive_cfg(1'b1, 2'd0, 32'd1, 1'b1);
            else             drive_cfg(1'b0, 2'd0, 32'd0, 1'b0);
            if (k <= 3)
                e = '{tag: "reset_mid", k: k, tick: {4{d_tick(k)}}, cout: {4{d_cout(k)}},
                      busy: (k >= 2) ? 4'b0010 : 4'b0000};
            else if (k == 4)
                e = '{tag: "reset_mid", k: k, tick: 4'b0, cout: 4'b0, busy: 4'b0};
            else
                e = '{tag: "reset_mid", k: k, tick: {4{d_tick(k - 4)}}, cout: {4{d_cout(k - 4)}},
                      busy: 4'b0};
            sb.push_back(e);
            step();
            e = sb.pop_front();
            vectors += 3;
            if (tick !== e.tick) begin miscompares++; $display("FAIL %s k=%0d tick got=%b exp=%b", e.tag, e.k, tick, e.tick); end
            if (cout !== e.cout) begin miscompares++; $display("FAIL %s k=%0d cout got=%b exp=%b", e.tag, e.k, cout, e.cout); end
            if (cfg.cfg_busy !== e.busy) begin miscompares++; $display("FAIL %s k=%0d busy got=%b exp=%b", e.tag, e.k, cfg.cfg_busy, e.busy); end
        end
        reset = 1'b0;
        drive_cfg(1'b0, 2'd0, 32'd0, 1'b0);
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1'b1;
        en    = 4'b0000;
        drive_cfg(1'b0, 2'd0, 32'd0, 1'b0);
        cfg3.cfg_we   = 1'b0;
        cfg3.cfg_ch   = 2'd0;
        cfg3.cfg_div  = 32'd0;
        cfg3.cfg_mode = 1'b0;
        #2;
        test_reset();
        test_default();
        test_pulse_reprogram();
        test_div_zero_one();
        test_freeze();
        test_last_write_wins();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
